// File: rtl/mpmc9_pkg.sv
// Shared types and constants for the mpmc9 request-side strip issuer.
package mpmc9_pkg;

  typedef enum logic [1:0] {
    RQ_IDLE  = 2'd0,
    RQ_ISSUE = 2'd1,
    RQ_FIN   = 2'd2
  } mpmc9_req_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // One bit wider than the 6-bit strip index so 64 strips cannot wrap.
  localparam int CNT_W = 7;

  function automatic logic [2:0] cmd_code(input logic is_write);
    return is_write ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/mpmc9_req_addr_gen.sv
// Strip address generator: base latched at burst start plus count scaled to
// the strip size, truncated to the app_addr width.
module mpmc9_req_addr_gen
  import mpmc9_pkg::*;
#(
  parameter int AMSB     = 28,
  parameter int STRIP_SH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [AMSB:0]    base,
  input  logic [CNT_W-1:0] count,
  output logic [AMSB:0]    addr
);

  logic [AMSB:0] base_r;
  logic [AMSB:0] offset_s;

  // Base address register, captured on burst start.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= {(AMSB+1){1'b0}};
    end else if (load) begin
      base_r <= base;
    end
  end

  // Address sum; overflow past the top of memory wraps by truncation.
  always_comb begin
    offset_s = (AMSB+1)'(count) << STRIP_SH;
    addr     = base_r + offset_s;
  end

endmodule

// File: rtl/mpmc9_req_strip_issue.sv
// mpmc9 request strip issuer: one DDR app command (plus one write-data beat for
// writes) per strip. Optional stall timeout enabled by MPMC9_REQ_TIMEOUT_EN.
module mpmc9_req_strip_issue
  import mpmc9_pkg::*;
#(
  parameter int AMSB     = 28,
  parameter int WID      = 128,
  parameter int STRIP_SH = 4,
  parameter int TO_MAX   = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           we,
  input  logic [AMSB:0]  addr_base,
  input  logic [5:0]     num_strips,
  input  logic [WID-1:0] wdata,
  output logic [5:0]     wdata_idx,
  input  logic           app_rdy,
  output logic           app_en,
  output logic [2:0]     app_cmd,
  output logic [AMSB:0]  app_addr,
  input  logic           app_wdf_rdy,
  output logic           app_wdf_wren,
  output logic           app_wdf_end,
  output logic [WID-1:0] app_wdf_data,
  output logic           busy,
  output logic           done,
  output logic [5:0]     req_strip_cnt,
  output logic           err
);

  if (TO_MAX < 1) begin : g_to_max_range
    $error("mpmc9_req_strip_issue: TO_MAX must be at least 1");
  end

  mpmc9_req_state_t state_r, state_nxt;
  logic [CNT_W-1:0] cmd_cnt_r, cmd_cnt_nxt;
  logic [CNT_W-1:0] dat_cnt_r, dat_cnt_nxt;
  logic             we_r, we_nxt;
  logic [5:0]       num_r, num_nxt;
  logic             en_r, en_nxt;
  logic             wren_r, wren_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             load_s, cmd_acc_s, dat_acc_s, last_s;

`ifdef MPMC9_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_MAX + 1);
  logic [TO_W-1:0] stall_r, stall_nxt;
  logic            err_r, err_nxt;
  logic            stall_s, to_hit_s;

  assign stall_s  = (en_r && !app_rdy) || (wren_r && !app_wdf_rdy);
  assign to_hit_s = stall_s && (stall_r == TO_W'(TO_MAX - 1));
  assign err      = err_r;
`else
  assign err = 1'b0;
`endif

  assign cmd_acc_s = en_r && app_rdy;
  assign dat_acc_s = wren_r && app_wdf_rdy;
  assign last_s    = (cmd_cnt_r == {1'b0, num_r});

  mpmc9_req_addr_gen #(
    .AMSB     (AMSB),
    .STRIP_SH (STRIP_SH)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .base  (addr_base),
    .count (cmd_cnt_r),
    .addr  (app_addr)
  );

  // Next-state, counter and next-output logic.
  always_comb begin
    state_nxt   = state_r;
    cmd_cnt_nxt = cmd_cnt_r;
    dat_cnt_nxt = dat_cnt_r;
    we_nxt      = we_r;
    num_nxt     = num_r;
    load_s      = 1'b0;
`ifdef MPMC9_REQ_TIMEOUT_EN
    stall_nxt   = stall_r;
    err_nxt     = err_r;
`endif
    case (state_r)
      RQ_IDLE: begin
        if (start) begin
          state_nxt   = RQ_ISSUE;
          cmd_cnt_nxt = {CNT_W{1'b0}};
          dat_cnt_nxt = {CNT_W{1'b0}};
          we_nxt      = we;
          num_nxt     = num_strips;
          load_s      = 1'b1;
`ifdef MPMC9_REQ_TIMEOUT_EN
          stall_nxt   = {TO_W{1'b0}};
          err_nxt     = 1'b0;
`endif
        end else begin
          state_nxt = RQ_IDLE;
        end
      end
      RQ_ISSUE: begin
        if (cmd_acc_s) begin
          cmd_cnt_nxt = cmd_cnt_r + 7'd1;
        end else begin
          cmd_cnt_nxt = cmd_cnt_r;
        end
        if (dat_acc_s) begin
          dat_cnt_nxt = dat_cnt_r + 7'd1;
        end else begin
          dat_cnt_nxt = dat_cnt_r;
        end
`ifdef MPMC9_REQ_TIMEOUT_EN
        stall_nxt = stall_s ? (stall_r + TO_W'(1)) : {TO_W{1'b0}};
`endif
        if (cmd_acc_s && last_s) begin
          state_nxt = RQ_FIN;
`ifdef MPMC9_REQ_TIMEOUT_EN
        end else if (to_hit_s) begin
          state_nxt = RQ_FIN;
          err_nxt   = 1'b1;
`endif
        end else begin
          state_nxt = RQ_ISSUE;
        end
      end
      RQ_FIN: begin
        state_nxt = RQ_IDLE;
      end
      default: begin
        state_nxt = RQ_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != RQ_IDLE);
    done_nxt = (state_nxt == RQ_FIN);
    // Write lockstep: data for strip n goes out before command n, never more than one ahead.
    if (state_nxt == RQ_ISSUE) begin
      if (we_nxt) begin
        wren_nxt = (dat_cnt_nxt == cmd_cnt_nxt) && (dat_cnt_nxt <= {1'b0, num_nxt});
        en_nxt   = (dat_cnt_nxt == (cmd_cnt_nxt + 7'd1));
      end else begin
        wren_nxt = 1'b0;
        en_nxt   = (cmd_cnt_nxt <= {1'b0, num_nxt});
      end
    end else begin
      wren_nxt = 1'b0;
      en_nxt   = 1'b0;
    end
  end

  // State, counters, latched burst parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RQ_IDLE;
      cmd_cnt_r <= {CNT_W{1'b0}};
      dat_cnt_r <= {CNT_W{1'b0}};
      we_r      <= 1'b0;
      num_r     <= 6'd0;
      en_r      <= 1'b0;
      wren_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef MPMC9_REQ_TIMEOUT_EN
      stall_r   <= {TO_W{1'b0}};
      err_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt;
      cmd_cnt_r <= cmd_cnt_nxt;
      dat_cnt_r <= dat_cnt_nxt;
      we_r      <= we_nxt;
      num_r     <= num_nxt;
      en_r      <= en_nxt;
      wren_r    <= wren_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
`ifdef MPMC9_REQ_TIMEOUT_EN
      stall_r   <= stall_nxt;
      err_r     <= err_nxt;
`endif
    end
  end

  assign app_en        = en_r;
  assign app_cmd       = cmd_code(we_r);
  assign app_wdf_wren  = wren_r;
  assign app_wdf_end   = wren_r;
  assign app_wdf_data  = wdata;
  assign wdata_idx     = dat_cnt_r[5:0];
  assign req_strip_cnt = cmd_cnt_r[5:0];
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_mpmc9_req_strip_issue.sv
// Directed self-checking bench for mpmc9_req_strip_issue (default parameters).
module tb_mpmc9_req_strip_issue;

  logic         clk;
  logic         rst;
  logic         start;
  logic         we;
  logic [28:0]  addr_base;
  logic [5:0]   num_strips;
  logic [127:0] wdata;
  logic [5:0]   wdata_idx;
  logic         app_rdy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [28:0]  app_addr;
  logic         app_wdf_rdy;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_wdf_data;
  logic         busy;
  logic         done;
  logic [5:0]   req_strip_cnt;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;
  int acc   = 0;

  mpmc9_req_strip_issue dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .we            (we),
    .addr_base     (addr_base),
    .num_strips    (num_strips),
    .wdata         (wdata),
    .wdata_idx     (wdata_idx),
    .app_rdy       (app_rdy),
    .app_en        (app_en),
    .app_cmd       (app_cmd),
    .app_addr      (app_addr),
    .app_wdf_rdy   (app_wdf_rdy),
    .app_wdf_wren  (app_wdf_wren),
    .app_wdf_end   (app_wdf_end),
    .app_wdf_data  (app_wdf_data),
    .busy          (busy),
    .done          (done),
    .req_strip_cnt (req_strip_cnt),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic w, input logic [28:0] base, input logic [5:0] n);
    start = 1'b1; we = w; addr_base = base; num_strips = n;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; addr_base = 29'd0; num_strips = 6'd0;
    wdata = 128'd0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    step();
    step();
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", req_strip_cnt, 6'd0);
    chk("rst_widx", wdata_idx, 6'd0);
    rst = 1'b0;
    step();

    // 1: read, 4 strips, always ready
    app_rdy = 1'b1;
    chk("t1_pre_en", app_en, 1'b0);
    kick(1'b0, 29'h100, 6'd3);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cmd", app_cmd, 3'b001);
    for (int i = 0; i < 4; i++) begin
      chk("t1_en", app_en, 1'b1);
      chk("t1_addr", app_addr, 29'h100 + 29'(i * 16));
      chk("t1_done_early", done, 1'b0);
      step();
    end
    chk("t1_done", done, 1'b1);
    chk("t1_en_fin", app_en, 1'b0);
    chk("t1_cnt", req_strip_cnt, 6'd4);
    chk("t1_err", err, 1'b0);
    step();
    chk("t1_done_off", done, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // 2: read, 3 strips, ready low on cycles 2 and 3
    kick(1'b0, 29'h0, 6'd2);
    acc = 0;
    for (int c = 1; c <= 5; c++) begin
      app_rdy = (c != 2) && (c != 3);
      chk("t2_en", app_en, 1'b1);
      chk("t2_addr", app_addr, (c <= 1) ? 29'h0 : ((c <= 4) ? 29'h10 : 29'h20));
      if (app_en && app_rdy) acc++;
      step();
    end
    chk("t2_accepts", acc, 3);
    chk("t2_done", done, 1'b1);
    chk("t2_cnt", req_strip_cnt, 6'd3);
    step();

    // 3: write, 2 strips, lockstep data/command
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    kick(1'b1, 29'h200, 6'd1);
    wdata = 128'h0123456789abcdef_fedcba9876543210;
    chk("t3_c1_wren", app_wdf_wren, 1'b1);
    chk("t3_c1_end", app_wdf_end, 1'b1);
    chk("t3_c1_en", app_en, 1'b0);
    chk("t3_c1_idx", wdata_idx, 6'd0);
    chk("t3_c1_data", app_wdf_data, 128'h0123456789abcdef_fedcba9876543210);
    step();
    chk("t3_c2_en", app_en, 1'b1);
    chk("t3_c2_wren", app_wdf_wren, 1'b0);
    chk("t3_c2_end", app_wdf_end, 1'b0);
    chk("t3_c2_cmd", app_cmd, 3'b000);
    chk("t3_c2_addr", app_addr, 29'h200);
    step();
    wdata = 128'hdeadbeef_00000001_cafef00d_00000002;
    chk("t3_c3_wren", app_wdf_wren, 1'b1);
    chk("t3_c3_en", app_en, 1'b0);
    chk("t3_c3_idx", wdata_idx, 6'd1);
    chk("t3_c3_data", app_wdf_data, 128'hdeadbeef_00000001_cafef00d_00000002);
    step();
    chk("t3_c4_en", app_en, 1'b1);
    chk("t3_c4_addr", app_addr, 29'h210);
    chk("t3_c4_wren", app_wdf_wren, 1'b0);
    step();
    chk("t3_done", done, 1'b1);
    chk("t3_cnt", req_strip_cnt, 6'd2);
    step();

    // 4: read near top of memory, address wraps
    kick(1'b0, 29'h1FFFFFF0, 6'd1);
    chk("t4_addr0", app_addr, 29'h1FFFFFF0);
    step();
    chk("t4_addr1", app_addr, 29'h0);
    chk("t4_en1", app_en, 1'b1);
    step();
    chk("t4_done", done, 1'b1);
    step();

    // 5: reset mid-burst; start while busy ignored
    kick(1'b0, 29'h0, 6'd7);
    chk("t5_addr0", app_addr, 29'h0);
    step();
    start = 1'b1; we = 1'b1; addr_base = 29'h5000; num_strips = 6'd0;
    chk("t5_addr1", app_addr, 29'h10);
    step();
    start = 1'b0;
    chk("t5_cnt2", req_strip_cnt, 6'd2);
    chk("t5_addr2", app_addr, 29'h20);
    chk("t5_cmd_kept", app_cmd, 3'b001);
    chk("t5_wren_kept", app_wdf_wren, 1'b0);
    app_rdy = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_en", app_en, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_cnt", req_strip_cnt, 6'd0);
    app_rdy = 1'b1;
    step();
    step();
    chk("t5_quiet_en", app_en, 1'b0);
    chk("t5_quiet_busy", busy, 1'b0);

    // 7: single-strip write with data back-pressure
    app_wdf_rdy = 1'b0;
    kick(1'b1, 29'h400, 6'd0);
    chk("t7_c1_wren", app_wdf_wren, 1'b1);
    chk("t7_c1_en", app_en, 1'b0);
    step();
    chk("t7_c2_wren_held", app_wdf_wren, 1'b1);
    chk("t7_c2_no_cmd", app_en, 1'b0);
    app_wdf_rdy = 1'b1;
    step();
    chk("t7_c3_en", app_en, 1'b1);
    chk("t7_c3_wren", app_wdf_wren, 1'b0);
    chk("t7_c3_addr", app_addr, 29'h400);
    step();
    chk("t7_done", done, 1'b1);
    chk("t7_cnt", req_strip_cnt, 6'd1);
    step();

`ifdef MPMC9_REQ_TIMEOUT_EN
    // 6: stall timeout
    app_rdy = 1'b0;
    kick(1'b0, 29'h0, 6'd0);
    for (int k = 0; k < 254; k++) step();
    chk("t6_c255_en", app_en, 1'b1);
    chk("t6_c255_err", err, 1'b0);
    chk("t6_c255_done", done, 1'b0);
    step();
    chk("t6_err", err, 1'b1);
    chk("t6_done", done, 1'b1);
    chk("t6_en_drop", app_en, 1'b0);
    step();
    chk("t6_err_sticky", err, 1'b1);
    app_rdy = 1'b1;
    kick(1'b0, 29'h0, 6'd0);
    chk("t6_err_clr", err, 1'b0);
    chk("t6_restart_en", app_en, 1'b1);
    step();
    chk("t6_restart_done", done, 1'b1);
    step();
`else
    // without the timeout the block simply waits
    app_rdy = 1'b0;
    kick(1'b0, 29'h0, 6'd0);
    for (int k = 0; k < 300; k++) step();
    chk("t6_wait_en", app_en, 1'b1);
    chk("t6_wait_err", err, 1'b0);
    chk("t6_wait_done", done, 1'b0);
    app_rdy = 1'b1;
    step();
    chk("t6_wait_fin", done, 1'b1);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
